fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width per beat.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester beat accepted.
REQ-009 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-010 SHALL have port fifo_din  output  WIDTH  FIFO write data.
REQ-011 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  currently granted requester.
REQ-013 SHALL have port busy  output  1  high while in GRANT.

Function
REQ-014 SHALL implement two states: IDLE and GRANT.
REQ-015 IDLE: if any req_valid is high, SHALL register the round-robin winner into grant_id, clear the burst counter, and enter GRANT next cycle; otherwise stay in IDLE.
REQ-016 Round-robin SHALL search from last_grant+1 upward, wrapping modulo NUM_REQ; last_grant updates on every IDLE->GRANT transition.
REQ-017 GRANT: req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-018 A beat SHALL occur when req_valid[grant_id] && !fifo_full in GRANT; fifo_wr_en SHALL equal beat (combinational, same cycle).
REQ-019 fifo_din SHALL equal req_data of grant_id in GRANT and 0 otherwise.
REQ-020 Each beat SHALL increment the burst counter; the beat that brings the count to MAX_BURST SHALL return the arbiter to IDLE.
REQ-021 In GRANT, req_valid[grant_id] low SHALL return the arbiter to IDLE next cycle without a beat.
REQ-022 fifo_full high with valid high SHALL hold the grant indefinitely; the counter SHALL NOT advance and no write SHALL occur.
REQ-023 At least one IDLE cycle SHALL separate consecutive grants; a re-requesting single requester SHALL be re-granted after it.
REQ-024 fifo_wr_en SHALL never assert while fifo_full is high.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, last_grant=NUM_REQ-1, grant_id=0, counter=0.
REQ-026 During reset, req_ready, fifo_wr_en, fifo_din and busy SHALL be 0; reset mid-burst SHALL drop the grant with no partial write.
REQ-027 After reset release, requester 0 SHALL win the first contended arbitration.

Configuration
REQ-028 Macro FIFO_WR_ARBITER_STATS_EN defined: SHALL add output beat_cnt (16 bits), counting every fifo_wr_en beat, wrapping at 65535->0, cleared by reset.
REQ-029 Macro undefined: beat_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 fifo_arb_pkg SHALL hold the IDLE/GRANT state encodings and the grant-width helper constant.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: winner index, any_req).

Verification
REQ-032 Reset, req_valid=4'b1111, no full -> grants 0,1,2,3,0 in order; each grant writes 4 beats; one IDLE cycle between grants.
REQ-033 Only requester 2 valid for 3 beats then drops -> 3 writes carrying its data, then IDLE; busy low the following cycle.
REQ-034 fifo_full high for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those cycles; burst resumes and totals exactly MAX_BURST beats.
REQ-035 rst_n pulled low on the 2nd beat of a grant -> outputs 0 immediately; after release requester 0 is granted first.
REQ-036 With FIFO_WR_ARBITER_STATS_EN, 70000 beats -> beat_cnt reads 4464.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: state encoding and grant-index width.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_GRANT_W = grant_w(4);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping to the lowest one.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      winner,
  output logic               any_req
);

  logic [GW-1:0] pick_upper;
  logic [GW-1:0] pick_all;
  logic          has_upper;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    pick_upper = '0;
    pick_all   = '0;
    has_upper  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[GW'(i)]) begin
        pick_all = GW'(i);
        if (GW'(i) > last_grant) begin
          pick_upper = GW'(i);
          has_upper  = 1'b1;
        end
      end
    end
  end

  assign any_req = |req;
  assign winner  = has_upper ? pick_upper : pick_all;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ write streams into one FIFO write port.
// Optional beat counter output beat_cnt is added when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic                       fifo_full,
  output logic [grant_w(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [15:0]                beat_cnt
`endif
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_reg, state_next;
  logic [GW-1:0] grant_id_reg, grant_id_next;
  logic [GW-1:0] last_grant_reg, last_grant_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          cur_valid;
  logic          beat;
  logic [WIDTH-1:0] req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    cur_valid       = req_valid[grant_id_reg];
    beat            = 1'b0;
    req_ready       = '0;
    fifo_din        = '0;
    busy            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next      = ST_GRANT;
          grant_id_next   = winner;
          last_grant_next = winner;
          burst_cnt_next  = '0;
        end
      end
      ST_GRANT: begin
        busy                    = 1'b1;
        beat                    = cur_valid && !fifo_full;
        req_ready[grant_id_reg] = !fifo_full;
        fifo_din                = req_word[grant_id_reg];
        // A dropped valid ends the burst; a full FIFO simply stalls it.
        if (!cur_valid) begin
          state_next = ST_IDLE;
        end else if (beat) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (burst_cnt_reg == CW'(MAX_BURST - 1)) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fifo_wr_en = beat;
  assign grant_id   = grant_id_reg;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] beat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (beat) begin
      beat_cnt_reg <= beat_cnt_reg + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_din;
  logic             fifo_full;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0]      beat_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the grant, how many beats it has written, who won last.
  bit m_busy;
  int m_gid;
  int m_last;
  int m_cnt;
  int m_beats;

  bit last_wr;
  bit last_busy;
  int last_gid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((v >> c) & 1) != 0) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_gid   = 0;
    m_last  = N - 1;
    m_cnt   = 0;
    m_beats = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},  32'(busy), 32'd0);
    check_val({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_din"},   32'(fifo_din), 32'd0);
    check_val({tag, "_gid"},   32'(grant_id), 32'd0);
  endtask

  // One clock of stimulus: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic f);
    bit          exp_wr;
    logic [N-1:0] exp_ready;
    logic [W-1:0] exp_din;
    logic [N*W-1:0] d;
    d = {$urandom, $urandom};
    req_valid = v;
    fifo_full = f;
    req_data  = d;
    #3;
    exp_wr    = m_busy && (((v >> m_gid) & 1) != 0) && !f;
    exp_ready = m_busy ? (N'(!f) << m_gid) : '0;
    exp_din   = m_busy ? W'(d >> (m_gid * W)) : '0;
    check_val("busy",  32'(busy), 32'(m_busy));
    check_val("gid",   32'(grant_id), 32'(m_gid));
    check_val("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    check_val("ready", 32'(req_ready), 32'(exp_ready));
    check_val("din",   32'(fifo_din), 32'(exp_din));
`ifdef FIFO_WR_ARBITER_STATS_EN
    check_val("beat_cnt", 32'(beat_cnt), 32'(m_beats % 65536));
`endif
    last_wr   = fifo_wr_en;
    last_busy = busy;
    last_gid  = int'(grant_id);
    @(posedge clk);
    if (!m_busy) begin
      if (v != '0) begin
        m_gid  = rr_winner(v, m_last);
        m_last = m_gid;
        m_cnt  = 0;
        m_busy = 1;
      end
    end else if (((v >> m_gid) & 1) == 0) begin
      m_busy = 0;
    end else if (!f) begin
      m_cnt++;
      m_beats++;
      if (m_cnt == MB) m_busy = 0;
    end
    #1;
  endtask

  int grants[$];
  int wr_count;
  int full_wr;
  bit prev_busy;
  logic [N-1:0] rv;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four requesting: grants rotate 0,1,2,3,0 with MB beats each.
    wr_count  = 0;
    prev_busy = 0;
    for (int i = 0; i < 25; i++) begin
      step(4'b1111, 1'b0);
      if (last_wr) wr_count++;
      if (last_busy && !prev_busy) grants.push_back(last_gid);
      prev_busy = last_busy;
    end
    check_val("t1_writes", 32'(wr_count), 32'(5 * MB));
    check_val("t1_ngrants", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      check_val("t1_g0", 32'(grants[0]), 32'd0);
      check_val("t1_g1", 32'(grants[1]), 32'd1);
      check_val("t1_g2", 32'(grants[2]), 32'd2);
      check_val("t1_g3", 32'(grants[3]), 32'd3);
      check_val("t1_g4", 32'(grants[4]), 32'd0);
    end
    step('0, 1'b0);

    // Requester 2 alone for three beats, then drops valid.
    wr_count = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, 1'b0);
      if (last_wr) wr_count++;
    end
    step('0, 1'b0);
    step('0, 1'b0);
    check_val("t2_writes", 32'(wr_count), 32'd3);
    check_val("t2_busy_after", 32'(last_busy), 32'd0);

    // FIFO full for five cycles in the middle of a burst.
    wr_count = 0;
    full_wr  = 0;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    if (last_wr) wr_count++;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      if (last_wr) full_wr++;
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0);
      if (last_wr) wr_count++;
    end
    check_val("t3_full_wr", 32'(full_wr), 32'd0);
    check_val("t3_burst_total", 32'(wr_count), 32'(MB));
    step('0, 1'b0);
    step('0, 1'b0);

    // Asynchronous reset on the second beat of a grant.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    #2;
    check_val("t4_pre_wr", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t4_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check_val("t4_first_busy", 32'(last_busy), 32'd1);
    check_val("t4_first_gid", 32'(last_gid), 32'd0);

    // Random traffic with sticky valids and occasional back-pressure.
    rv = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rv = N'($urandom_range(0, 15));
      step(rv, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
